spu_result_pipe: RTL and testbench
==================================

Name: spu_result_pipe

Overview:
- Parametrised result staging pipeline for the dual-issue SPU, carrying even- and odd-pipe results from execute to register-file writeback.
- Replaces the fixed single-stage even/odd result register with DEPTH staged slots per pipe.
- Adds stall, branch flush and a multi-port forwarding lookup across all in-flight stages.
- Sits between the even/odd execute units and the register-file write ports. Query ports feed operand bypass muxes in the issue stage.

Parameters:
- DEPTH, 6: number of result stages per pipe, minimum 2. Stage 0 is youngest; stage DEPTH-1 drives writeback.
- DATA_W, 128: result width.
- ADDR_W, 7: register address width.
- UID_W, 3: unit-id tag width.
- NQ, 3: number of forwarding query ports (ra/rb/rc).
- KILL_STAGES, 2: number of youngest stages cleared by flush, 0..DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  hold all stages
- flush  in  1  branch flush; kills incoming pair and young stages
- in_e_wreg  in  1  even result write enable
- in_e_addr  in  ADDR_W  even rt address
- in_e_data  in  DATA_W  even result
- in_e_uid  in  UID_W  even unit id
- in_o_wreg, in_o_addr, in_o_data, in_o_uid  in  1/ADDR_W/DATA_W/UID_W  odd-pipe equivalents
- q_addr  in  NQ*ADDR_W  query addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- q_hit  out  NQ  query k matched an in-flight valid result
- q_data  out  NQ*DATA_W  forwarded data for query k; 0 when no hit
- wb_e_wreg, wb_e_addr, wb_e_data, wb_e_uid  out  1/ADDR_W/DATA_W/UID_W  even stage DEPTH-1
- wb_o_wreg, wb_o_addr, wb_o_data, wb_o_uid  out  odd stage DEPTH-1

Behaviour:
- rst is synchronous and active-high.
  - On reset, every stage's wreg, addr, data and uid clear to 0.
  - All wb_* outputs therefore read 0 from the following edge.
  - q_hit and q_data are 0 while the pipe is empty.
- Reset takes priority over flush and stall. Reset mid-flight discards all in-flight results; nothing is written back.
- Advance (stall=0, flush=0):
  - Stage i+1 takes stage i.
  - Stage 0 takes the in_* fields.
  - Latency from in_* to wb_* is exactly DEPTH cycles.
- Stall (stall=1, flush=0): all stages hold. in_* is ignored and the upstream stage must hold its values.
- Flush (flush=1):
  - Stages 0..KILL_STAGES-1 get wreg=0 after the edge. Their addr, data and uid are don't-care.
  - The incoming pair is not captured.
  - With stall=0: older stages shift normally; stage 0 gets wreg=0 and the killed stages' contents shift out with wreg=0.
  - With stall=1: older stages hold; only the wreg clear applies.
  - KILL_STAGES=0: flush only blocks the incoming pair.
- Write-back stage: wb_* fields are registered stage DEPTH-1 contents, with no combinational path from in_*. Under stall, wb_* holds its value; the register file must gate its write with stall.
- Forwarding (combinational from stage registers and q_addr; the incoming in_* pair is not searched):
  - A candidate is any stage s and pipe p with wreg=1 and addr equal to q_addr[k].
  - Priority goes to the youngest stage (lowest s).
  - Within one stage, odd beats even, because odd is later in program order.
  - q_data[k] is the winning candidate's data; q_hit[k]=1.
  - With no candidate, q_hit[k]=0 and q_data[k]=0.
  - Each query port is independent; identical q_addr on several ports returns identical results.
  - Address 0 is not special; it matches like any other.
- Widths: no arithmetic on data. Comparisons are full ADDR_W equality.

Optional Feature:
- Macro: SPU_RESULT_PIPE_STATS_EN.
- When defined, an extra output port fwd_hit_cnt (out, 32) is present.
  - It counts clock cycles in which any q_hit bit is 1 and stall=0.
  - It saturates at 0xFFFFFFFF and is cleared by rst.
  - It increments by 1 per qualifying cycle, regardless of how many ports hit.
- When not defined, the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then an even write addr=5 data=0xA5..A5 uid=1 with stall=0 -> wb_e_wreg=1, addr=5, data=0xA5..A5 exactly 6 cycles later; wb_o_wreg=0 throughout.
- Even addr=9 data=1 in cycle 0, then odd addr=9 data=2 in cycle 1, with q_addr[0]=9 -> cycle 1: hit data=1; cycle 2 onward: hit data=2 (stage 0 odd beats stage 1 even).
- Same-pair even and odd both addr=12, data 3 and 4 -> q_hit=1, q_data=4 (odd wins) for every query port set to 12.
- Pair loaded in cycle 0, then stall=1 for 4 cycles -> wb_* asserts at cycle 10 instead of 6; q_hit stays 1 throughout the stall.
- Results with addrs 20, 21, 22 in consecutive cycles, then flush=1 (KILL_STAGES=2) -> addr 20 survives and writes back; 21 and 22 never write back; q_hit for 21 and 22 is 0 from the next cycle.
- Pipe full of valid results, then rst=1 for one cycle -> all wb_* and q_hit are 0 after the edge. With SPU_RESULT_PIPE_STATS_EN, fwd_hit_cnt returns to 0 after the edge and counts exactly 3 after 3 unstalled hit cycles.

Source files
------------

// File: rtl/spu_result_pipe.sv
// spu_result_pipe: result staging pipeline for the dual-issue SPU.
//
// Carries even- and odd-pipe results through DEPTH registered stages from
// execute to register-file writeback. Stage 0 is youngest; stage DEPTH-1
// drives the wb_* ports. Supports stall (hold everything), branch flush
// (kill the incoming pair and the KILL_STAGES youngest stages) and NQ
// forwarding query ports that search every in-flight stage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               hold all stages, ignore in_*
//   flush               branch flush
//   in_{e,o}_*          incoming even/odd result (wreg, addr, data, uid)
//   q_addr              NQ packed query addresses (port k at [k*ADDR_W +: ADDR_W])
//   q_hit, q_data       per-port hit flag and forwarded data (0 on miss)
//   wb_{e,o}_*          registered contents of stage DEPTH-1
//   fwd_hit_cnt         saturating count of unstalled cycles with any hit
//                       (present only when SPU_RESULT_PIPE_STATS_EN is defined)
//
// DEPTH must be at least 2.

module spu_result_pipe #(
    parameter int unsigned DEPTH       = 6,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned UID_W       = 3,
    parameter int unsigned NQ          = 3,
    parameter int unsigned KILL_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,

    input  logic                 in_e_wreg,
    input  logic [ADDR_W-1:0]    in_e_addr,
    input  logic [DATA_W-1:0]    in_e_data,
    input  logic [UID_W-1:0]     in_e_uid,
    input  logic                 in_o_wreg,
    input  logic [ADDR_W-1:0]    in_o_addr,
    input  logic [DATA_W-1:0]    in_o_data,
    input  logic [UID_W-1:0]     in_o_uid,

    input  logic [NQ*ADDR_W-1:0] q_addr,
    output logic [NQ-1:0]        q_hit,
    output logic [NQ*DATA_W-1:0] q_data,

    output logic                 wb_e_wreg,
    output logic [ADDR_W-1:0]    wb_e_addr,
    output logic [DATA_W-1:0]    wb_e_data,
    output logic [UID_W-1:0]     wb_e_uid,
    output logic                 wb_o_wreg,
    output logic [ADDR_W-1:0]    wb_o_addr,
    output logic [DATA_W-1:0]    wb_o_data,
    output logic [UID_W-1:0]     wb_o_uid
`ifdef SPU_RESULT_PIPE_STATS_EN
    ,
    output logic [31:0]          fwd_hit_cnt
`endif
);

    // Stage state, one entry per stage, index 0 youngest.
    logic [DEPTH-1:0]             e_wreg_q, e_wreg_d, o_wreg_q, o_wreg_d;
    logic [DEPTH-1:0][ADDR_W-1:0] e_addr_q, e_addr_d, o_addr_q, o_addr_d;
    logic [DEPTH-1:0][DATA_W-1:0] e_data_q, e_data_d, o_data_q, o_data_d;
    logic [DEPTH-1:0][UID_W-1:0]  e_uid_q,  e_uid_d,  o_uid_q,  o_uid_d;

    // Stages whose current contents are killed by a flush this cycle.
    logic [DEPTH-1:0] kill_mask;
    logic [DEPTH-1:0] e_live, o_live;

    always_comb begin
        kill_mask = '0;
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i < int'(KILL_STAGES)) kill_mask[i] = 1'b1;
            end
        end
    end

    assign e_live = e_wreg_q & ~kill_mask;
    assign o_live = o_wreg_q & ~kill_mask;

    always_comb begin
        e_wreg_d = e_wreg_q;
        e_addr_d = e_addr_q;
        e_data_d = e_data_q;
        e_uid_d  = e_uid_q;
        o_wreg_d = o_wreg_q;
        o_addr_d = o_addr_q;
        o_data_d = o_data_q;
        o_uid_d  = o_uid_q;
        if (rst) begin
            e_wreg_d = '0;
            e_addr_d = '0;
            e_data_d = '0;
            e_uid_d  = '0;
            o_wreg_d = '0;
            o_addr_d = '0;
            o_data_d = '0;
            o_uid_d  = '0;
        end else if (stall) begin
            // Hold everything; a flush still clears the young valid bits.
            e_wreg_d = e_live;
            o_wreg_d = o_live;
        end else begin
            // Killed contents shift onward with wreg already cleared.
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                e_wreg_d[i] = e_live[i-1];
                e_addr_d[i] = e_addr_q[i-1];
                e_data_d[i] = e_data_q[i-1];
                e_uid_d[i]  = e_uid_q[i-1];
                o_wreg_d[i] = o_live[i-1];
                o_addr_d[i] = o_addr_q[i-1];
                o_data_d[i] = o_data_q[i-1];
                o_uid_d[i]  = o_uid_q[i-1];
            end
            e_wreg_d[0] = in_e_wreg & ~flush;
            e_addr_d[0] = in_e_addr;
            e_data_d[0] = in_e_data;
            e_uid_d[0]  = in_e_uid;
            o_wreg_d[0] = in_o_wreg & ~flush;
            o_addr_d[0] = in_o_addr;
            o_data_d[0] = in_o_data;
            o_uid_d[0]  = in_o_uid;
        end
    end

    always_ff @(posedge clk) begin
        e_wreg_q <= e_wreg_d;
        e_addr_q <= e_addr_d;
        e_data_q <= e_data_d;
        e_uid_q  <= e_uid_d;
        o_wreg_q <= o_wreg_d;
        o_addr_q <= o_addr_d;
        o_data_q <= o_data_d;
        o_uid_q  <= o_uid_d;
    end

    // Forwarding: walk oldest to youngest, even before odd, so the last
    // match assigned is the youngest stage with odd winning within a stage.
    always_comb begin
        q_hit  = '0;
        q_data = '0;
        for (int k = 0; k < int'(NQ); k++) begin
            for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
                if (e_wreg_q[s] && (e_addr_q[s] == q_addr[k*ADDR_W +: ADDR_W])) begin
                    q_hit[k]                  = 1'b1;
                    q_data[k*DATA_W +: DATA_W] = e_data_q[s];
                end
                if (o_wreg_q[s] && (o_addr_q[s] == q_addr[k*ADDR_W +: ADDR_W])) begin
                    q_hit[k]                  = 1'b1;
                    q_data[k*DATA_W +: DATA_W] = o_data_q[s];
                end
            end
        end
    end

    assign wb_e_wreg = e_wreg_q[DEPTH-1];
    assign wb_e_addr = e_addr_q[DEPTH-1];
    assign wb_e_data = e_data_q[DEPTH-1];
    assign wb_e_uid  = e_uid_q[DEPTH-1];
    assign wb_o_wreg = o_wreg_q[DEPTH-1];
    assign wb_o_addr = o_addr_q[DEPTH-1];
    assign wb_o_data = o_data_q[DEPTH-1];
    assign wb_o_uid  = o_uid_q[DEPTH-1];

`ifdef SPU_RESULT_PIPE_STATS_EN
    logic [31:0] fwd_hit_cnt_q, fwd_hit_cnt_d;

    // One count per unstalled cycle with any hit, saturating.
    always_comb begin
        fwd_hit_cnt_d = fwd_hit_cnt_q;
        if (rst) begin
            fwd_hit_cnt_d = '0;
        end else if ((|q_hit) && !stall && (fwd_hit_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_hit_cnt_d = fwd_hit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        fwd_hit_cnt_q <= fwd_hit_cnt_d;
    end

    assign fwd_hit_cnt = fwd_hit_cnt_q;
`endif

endmodule

// File: tb/tb_spu_result_pipe.sv
// Directed testbench for spu_result_pipe with default parameters
// (DEPTH=6, KILL_STAGES=2, NQ=3). Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, away from the edge.

module tb_spu_result_pipe;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 7;
    localparam int UID_W  = 3;
    localparam int NQ     = 3;

    logic                 clk = 1'b0;
    logic                 rst, stall, flush;
    logic                 in_e_wreg, in_o_wreg;
    logic [ADDR_W-1:0]    in_e_addr, in_o_addr;
    logic [DATA_W-1:0]    in_e_data, in_o_data;
    logic [UID_W-1:0]     in_e_uid, in_o_uid;
    logic [NQ*ADDR_W-1:0] q_addr;
    logic [NQ-1:0]        q_hit;
    logic [NQ*DATA_W-1:0] q_data;
    logic                 wb_e_wreg, wb_o_wreg;
    logic [ADDR_W-1:0]    wb_e_addr, wb_o_addr;
    logic [DATA_W-1:0]    wb_e_data, wb_o_data;
    logic [UID_W-1:0]     wb_e_uid, wb_o_uid;
`ifdef SPU_RESULT_PIPE_STATS_EN
    logic [31:0]          fwd_hit_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spu_result_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_e_wreg (in_e_wreg),
        .in_e_addr (in_e_addr),
        .in_e_data (in_e_data),
        .in_e_uid  (in_e_uid),
        .in_o_wreg (in_o_wreg),
        .in_o_addr (in_o_addr),
        .in_o_data (in_o_data),
        .in_o_uid  (in_o_uid),
        .q_addr    (q_addr),
        .q_hit     (q_hit),
        .q_data    (q_data),
        .wb_e_wreg (wb_e_wreg),
        .wb_e_addr (wb_e_addr),
        .wb_e_data (wb_e_data),
        .wb_e_uid  (wb_e_uid),
        .wb_o_wreg (wb_o_wreg),
        .wb_o_addr (wb_o_addr),
        .wb_o_data (wb_o_data),
        .wb_o_uid  (wb_o_uid)
`ifdef SPU_RESULT_PIPE_STATS_EN
        ,
        .fwd_hit_cnt (fwd_hit_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_e_wreg = 1'b0; in_e_addr = '0; in_e_data = '0; in_e_uid = '0;
        in_o_wreg = 1'b0; in_o_addr = '0; in_o_data = '0; in_o_uid = '0;
    endtask

    task automatic set_q(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                         input logic [ADDR_W-1:0] a2);
        q_addr = {a2, a1, a0};
    endtask

    task automatic drain();
        clear_in();
        for (int i = 0; i < 7; i++) tick();
    endtask

    function automatic logic [DATA_W-1:0] qd(input int k);
        return q_data[k*DATA_W +: DATA_W];
    endfunction

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        clear_in();
        set_q(7'd0, 7'd0, 7'd0);
        tick(); tick();
        rst = 1'b0;

        // Reset state: empty pipe, address 0 must not hit.
        check("rst_wb_e_wreg", wb_e_wreg, 0);
        check("rst_wb_o_wreg", wb_o_wreg, 0);
        check("rst_wb_e_data", wb_e_data, 0);
        check("rst_q_hit", q_hit, 0);
        check("rst_q_data", q_data[127:0], 0);

        // Single even write, latency exactly 6.
        in_e_wreg = 1'b1; in_e_addr = 7'd5; in_e_data = {16{8'hA5}}; in_e_uid = 3'd1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            clear_in();
            check($sformatf("lat_e_wreg_%0d", n), wb_e_wreg, (n == 6));
            check($sformatf("lat_o_wreg_%0d", n), wb_o_wreg, 0);
        end
        check("lat_e_addr", wb_e_addr, 5);
        check("lat_e_data", wb_e_data, {16{8'hA5}});
        check("lat_e_uid", wb_e_uid, 1);
        tick();
        check("lat_e_wreg_after", wb_e_wreg, 0);
        drain();

        // Youngest stage wins; odd stage 0 beats even stage 1.
        set_q(7'd9, 7'd0, 7'd0);
        in_e_wreg = 1'b1; in_e_addr = 7'd9; in_e_data = 128'd1;
        tick();
        clear_in();
        in_o_wreg = 1'b1; in_o_addr = 7'd9; in_o_data = 128'd2;
        #1;
        check("fwd_c1_hit", q_hit[0], 1);
        check("fwd_c1_data", qd(0), 1);
        tick();
        clear_in();
        check("fwd_c2_hit", q_hit[0], 1);
        check("fwd_c2_data", qd(0), 2);
        tick();
        check("fwd_c3_data", qd(0), 2);
        drain();

        // Same pair, same address: odd wins on every port.
        set_q(7'd12, 7'd12, 7'd12);
        in_e_wreg = 1'b1; in_e_addr = 7'd12; in_e_data = 128'd3;
        in_o_wreg = 1'b1; in_o_addr = 7'd12; in_o_data = 128'd4;
        tick();
        clear_in();
        check("pair_hit", q_hit, 3'b111);
        for (int k = 0; k < NQ; k++) check($sformatf("pair_data_%0d", k), qd(k), 4);
        drain();

        // Stall for 4 cycles after loading: writeback at edge 10.
        set_q(7'd30, 7'd31, 7'd0);
        in_e_wreg = 1'b1; in_e_addr = 7'd30; in_e_data = 128'h30;
        in_o_wreg = 1'b1; in_o_addr = 7'd31; in_o_data = 128'h31;
        tick();
        stall = 1'b1;
        // Junk on in_* during stall must be ignored.
        in_e_data = 128'hDEAD; in_o_data = 128'hBEEF;
        for (int n = 2; n <= 5; n++) begin
            tick();
            check($sformatf("stall_hit_%0d", n), q_hit[1:0], 2'b11);
            check($sformatf("stall_data_%0d", n), qd(0), 128'h30);
        end
        stall = 1'b0;
        clear_in();
        for (int n = 6; n <= 10; n++) begin
            tick();
            check($sformatf("stall_wb_%0d", n), wb_o_wreg, (n == 10));
        end
        check("stall_wb_o_addr", wb_o_addr, 31);
        check("stall_wb_e_data", wb_e_data, 128'h30);
        drain();

        // Flush with 20, 21, 22 in stages 2, 1, 0: only 20 survives.
        set_q(7'd20, 7'd21, 7'd22);
        for (int a = 20; a <= 22; a++) begin
            in_e_wreg = 1'b1; in_e_addr = ADDR_W'(a); in_e_data = 128'(a);
            tick();
        end
        flush = 1'b1;
        in_e_addr = 7'd23;
        tick();
        flush = 1'b0;
        clear_in();
        check("flush_hit", q_hit, 3'b001);
        set_q(7'd20, 7'd21, 7'd23);
        #1;
        check("flush_in_blocked", q_hit[2], 0);
        for (int n = 1; n <= 5; n++) begin
            tick();
            check($sformatf("flush_wb_%0d", n), wb_e_wreg, (n == 2));
            if (n == 2) check("flush_wb_addr", wb_e_addr, 20);
        end
        drain();

        // Fill the pipe, check address 0 and miss data, then reset mid-flight.
        for (int i = 0; i < 6; i++) begin
            in_e_wreg = 1'b1; in_e_addr = ADDR_W'(i);      in_e_data = 128'h100 + 128'(i);
            in_o_wreg = 1'b1; in_o_addr = ADDR_W'(i + 32); in_o_data = 128'h200 + 128'(i);
            tick();
        end
        clear_in();
        set_q(7'd0, 7'd35, 7'd7);
        #1;
        check("full_hit", q_hit, 3'b011);
        check("full_addr0_data", qd(0), 128'h100);
        check("full_odd_data", qd(1), 128'h203);
        check("full_miss_data", qd(2), 0);
        check("full_wb_e", wb_e_wreg, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_wb_e", wb_e_wreg, 0);
        check("mid_rst_wb_o", wb_o_wreg, 0);
        check("mid_rst_wb_data", wb_o_data, 0);
        check("mid_rst_q_hit", q_hit, 0);
        check("mid_rst_q_data", qd(1), 0);
`ifdef SPU_RESULT_PIPE_STATS_EN
        check("cnt_rst", fwd_hit_cnt, 0);
`endif
        tick();
        check("post_rst_wb_e", wb_e_wreg, 0);
        check("post_rst_wb_o", wb_o_wreg, 0);

`ifdef SPU_RESULT_PIPE_STATS_EN
        set_q(7'd50, 7'd50, 7'd0);
        in_e_wreg = 1'b1; in_e_addr = 7'd50; in_e_data = 128'h50;
        tick();
        clear_in();
        check("cnt_load", fwd_hit_cnt, 0);
        for (int n = 0; n < 3; n++) tick();
        check("cnt_three", fwd_hit_cnt, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
